cmd_arbiter: RTL
================

Name: cmd_arbiter

Overview:
- Shares the single command input of the station/command FSM between N_SRC command sources: BLE112 UART receiver (src 0) and bench/debug UART (src 1).
- Latches one winning 8-bit command, presents it as cmd/cmd_rdy, and holds it until the FSM acknowledges with clr_cmd_rdy.
- Stop commands (cmd[7:6]==00) preempt everything else; a watchdog drops commands the FSM never consumes.

Parameters:
N_SRC, 2, number of command sources (2..4)
TIMEOUT_CYC, 50_000_000, cycles cmd_rdy may stay high unacknowledged (1 s at 50 MHz)
TMR_W, $clog2(TIMEOUT_CYC), watchdog counter width

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous, active-high reset
src_cmd  in  8*N_SRC  packed commands, src i at [8i+7:8i]
src_vld  in  N_SRC  src i has a command; held until its src_clr
src_clr  out  N_SRC  one-cycle pulse: src i's command taken
cmd  out  8  held command to command FSM
cmd_rdy  out  1  cmd valid
clr_cmd_rdy  in  1  FSM consumed cmd (one-cycle pulse)
drop_err  out  1  one-cycle pulse: held cmd dropped on timeout
preempt  out  1  one-cycle pulse: held non-stop cmd replaced by a stop
busy  out  1  state != IDLE

Behaviour:
- Reset (rst sampled high at clk edge): state=IDLE, cmd=8'h00, cmd_rdy=0, src_clr=0, drop_err=0, preempt=0, rr_ptr=0, timer=0. Reset mid-PRESENT discards the held command with no src_clr and no drop_err.
- All outputs are registered. The decode is is_stop = (cmd[7:6]==2'b00).
- Grant class: if any valid source holds a stop, only stop requesters compete. Otherwise all valid sources compete. Within the class, round-robin starts at rr_ptr; the winner w sets rr_ptr <= (w+1) mod N_SRC.
- States: IDLE, PRESENT, GAP.
  - IDLE: if any src_vld at edge n, latch winner: cmd<=src_cmd[w], src_clr[w]=1 and cmd_rdy=1 during cycle n+1, timer<=0, go to PRESENT. Otherwise stay.
  - PRESENT: cmd_rdy=1, timer increments each cycle.
    - clr_cmd_rdy=1: go to GAP.
    - Else if timer==TIMEOUT_CYC-1: drop_err pulse next cycle, go to GAP.
    - Else if held cmd is not a stop and some src holds a stop: grant that stop by the rule above, cmd<=stop, src_clr pulse, preempt pulse, timer<=0, stay in PRESENT. cmd_rdy never deasserts across a preempt.
  - GAP: cmd_rdy=0 for exactly one cycle, then IDLE. Guarantees the FSM sees a fresh rising cmd_rdy per command.
- Priority of simultaneous PRESENT events: clr_cmd_rdy > timeout > preempt. A stop arriving on the same edge as clr stays pending and is granted from IDLE.
- A held stop is never preempted, including by a newer stop.
- src_clr is never asserted for a source whose src_vld was low at the granting edge. At most one src_clr bit is high per cycle.
- Throughput: best case one command per 3 cycles (IDLE, PRESENT with immediate clr, GAP).
- clr_cmd_rdy in IDLE or GAP is ignored.

Decomposition:
- Shared package cmd_pkg: typedef enum logic [1:0] {CMD_STOP=2'b00, CMD_GO=2'b01} cmd_op_t; function is_stop(logic [7:0]); typedef enum logic [1:0] {IDLE, PRESENT, GAP} arb_state_t.
- One sub-module rr_pick: purely combinational. Inputs are request vector, class mask and rr_ptr; outputs are one-hot grant and binary index. It is reused for both the normal grant and the stop-preempt grant.

Test Plan (N_SRC=2, TIMEOUT_CYC=16):
- Single request: src0 cmd=8'h45, vld=1 at edge 0, clr_cmd_rdy pulsed at cycle 3 -> src_clr=2'b01 and cmd_rdy=1/cmd=8'h45 in cycle 1; cmd_rdy=0 in cycle 4 (GAP); busy=0 from cycle 5.
- Round-robin: both srcs hold go cmds 8'h41/8'h42 continuously, FSM acks immediately -> grant order 0,1,0,1; cmd sequence 41,42,41,42.
- Stop priority: src0=8'h41, src1=8'h00 both valid in IDLE, rr_ptr=0 -> src1 granted first (cmd=8'h00); rr_ptr becomes 0; src0 granted next.
- Preempt: holding 8'h41 un-acked, src1 asserts 8'h00 at cycle 5 -> cycle 6: cmd=8'h00, preempt=1, src_clr=2'b10, cmd_rdy stays 1, timer restarts.
- Timeout: hold 8'h41, never ack -> drop_err pulses 16 cycles after grant; GAP; no src_clr repeat.
- Collision and reset: clr_cmd_rdy and a new stop on the same edge -> no preempt, stop granted after GAP. rst high mid-PRESENT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/cmd_pkg.sv
// cmd_pkg: command opcodes, arbiter states and stop decode shared by the arbiter
package cmd_pkg;
  typedef enum logic [1:0] {CMD_STOP = 2'b00, CMD_GO = 2'b01} cmd_op_t;
  typedef enum logic [1:0] {IDLE, PRESENT, GAP} arb_state_t;
  function automatic logic is_stop(input logic [7:0] c);
    return c[7:6] == CMD_STOP;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick among masked requests, starting at ptr_i
module rr_pick #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic [N-1:0] el;
  logic [IW:0] s;
  logic found;
  assign el = req_i & mask_i;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    s = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr_i} + (IW+1)'(k);
      s = (s >= (IW+1)'(N)) ? s - (IW+1)'(N) : s;
      if (!found && el[s[IW-1:0]]) begin
        found = 1'b1;
        gnt_o[s[IW-1:0]] = 1'b1;
        idx_o = s[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: shares the command FSM input between N_SRC sources with stop preemption and an ack watchdog
module cmd_arbiter
  import cmd_pkg::*;
#(
  parameter int N_SRC       = 2,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int TMR_W       = $clog2(TIMEOUT_CYC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_SRC-1:0] src_cmd,
  input  logic [N_SRC-1:0]   src_vld,
  output logic [N_SRC-1:0]   src_clr,
  output logic [7:0]         cmd,
  output logic               cmd_rdy,
  input  logic               clr_cmd_rdy,
  output logic               drop_err,
  output logic               preempt,
  output logic               busy
);
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  arb_state_t state_q;
  logic [7:0] cmd_q;
  logic rdy_q, drop_q, pre_q, any_stop;
  logic [N_SRC-1:0] clr_q, stop_req, gnt;
  logic [IW-1:0] rr_q, rr_d, idx;
  logic [TMR_W-1:0] tmr_q;
  logic [7:0] cmds [N_SRC];
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign cmds[i] = src_cmd[8*i +: 8];
    assign stop_req[i] = src_vld[i] & is_stop(cmds[i]);
  end
  assign any_stop = |stop_req;
  // one picker serves both the idle grant and the preempt grant: when a stop is pending the class is stops only
  rr_pick #(.N(N_SRC)) u_pick (
    .req_i (src_vld),
    .mask_i(any_stop ? stop_req : {N_SRC{1'b1}}),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .idx_o (idx)
  );
  assign rr_d = (idx == IW'(N_SRC-1)) ? '0 : idx + 1'b1;
  always_ff @(posedge clk) begin
    clr_q  <= '0;
    drop_q <= 1'b0;
    pre_q  <= 1'b0;
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      rdy_q   <= 1'b0;
      rr_q    <= '0;
      tmr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (|src_vld) begin
          cmd_q   <= cmds[idx];
          clr_q   <= gnt;
          rdy_q   <= 1'b1;
          tmr_q   <= '0;
          rr_q    <= rr_d;
          state_q <= PRESENT;
        end
        PRESENT: if (clr_cmd_rdy) begin
          rdy_q   <= 1'b0;
          state_q <= GAP;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYC-1)) begin
          drop_q  <= 1'b1;
          rdy_q   <= 1'b0;
          state_q <= GAP;
        end else if (!is_stop(cmd_q) && any_stop) begin
          cmd_q <= cmds[idx];
          clr_q <= gnt;
          pre_q <= 1'b1;
          tmr_q <= '0;
          rr_q  <= rr_d;
        end else begin
          tmr_q <= tmr_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign src_clr  = clr_q;
  assign cmd      = cmd_q;
  assign cmd_rdy  = rdy_q;
  assign drop_err = drop_q;
  assign preempt  = pre_q;
  assign busy     = state_q != IDLE;
endmodule
